// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: steps the eight-phase instruction cycle, puts the PC on the
// ROM bus one nibble at a time, and latches the opcode, operand and second word for the decoder.
module fetch_sequencer #(
    parameter int PC_WIDTH = 12
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                hold,
    input  logic [3:0]          romData,
    input  logic                jumpEn,
    input  logic [PC_WIDTH-1:0] jumpAddr,
    output logic [2:0]          cycle,
    output logic                sync,
    output logic [3:0]          addrOut,
    output logic [3:0]          opr,
    output logic [3:0]          opa,
    output logic                secondWord,
    output logic [7:0]          operand2,
    output logic [PC_WIDTH-1:0] pc
);

    typedef enum logic [2:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } phase_t;

    phase_t phase;
    logic   pendingSecond;
    logic   twoWordOp;

    assign cycle = phase;
    assign sync  = (phase == X3);

    // JCN, JUN, JMS and ISZ always take a second word; opcode 2 does only for FIM (even opa).
    assign twoWordOp = (opr == 4'h1) || (opr == 4'h4) || (opr == 4'h5) || (opr == 4'h7) ||
                       ((opr == 4'h2) && !romData[0]);

    always_comb begin
        addrOut = 4'h0;
        case (phase)
            A1:      addrOut = pc[3:0];
            A2:      addrOut = pc[7:4];
            A3:      addrOut = pc[11:8];
            default: addrOut = 4'h0;
        endcase
    end

    // A second-word cycle steers the ROM nibbles into operand2 and leaves opr/opa alone,
    // which also keeps detection from chaining into a third word.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            phase         <= A1;
            pc            <= '0;
            opr           <= 4'h0;
            opa           <= 4'h0;
            operand2      <= 8'h00;
            secondWord    <= 1'b0;
            pendingSecond <= 1'b0;
        end else if (!hold) begin
            phase <= phase_t'(phase + 3'd1);
            case (phase)
                M1: begin
                    if (secondWord) begin
                        operand2[7:4] <= romData;
                    end else begin
                        opr <= romData;
                    end
                end
                M2: begin
                    if (secondWord) begin
                        operand2[3:0] <= romData;
                    end else begin
                        opa <= romData;
                        if (twoWordOp) begin
                            pendingSecond <= 1'b1;
                        end
                    end
                end
                X3: begin
                    pendingSecond <= 1'b0;
                    if (jumpEn) begin
                        pc         <= jumpAddr;
                        secondWord <= 1'b0;
                    end else begin
                        pc         <= pc + PC_WIDTH'(1);
                        secondWord <= pendingSecond;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a per-instruction vector table, hand-written hold/reset sequences,
// then randomized traffic compared against an instruction-level reference model.
module tb_fetch_sequencer;

    logic        clk;
    logic        rstN;
    logic        hold;
    logic [3:0]  romData;
    logic        jumpEn;
    logic [11:0] jumpAddr;
    logic [2:0]  cycle;
    logic        sync;
    logic [3:0]  addrOut;
    logic [3:0]  opr;
    logic [3:0]  opa;
    logic        secondWord;
    logic [7:0]  operand2;
    logic [11:0] pc;

    int checks = 0;
    int fails  = 0;

    fetch_sequencer #(.PC_WIDTH(12)) dut (
        .clk        (clk),
        .rstN       (rstN),
        .hold       (hold),
        .romData    (romData),
        .jumpEn     (jumpEn),
        .jumpAddr   (jumpAddr),
        .cycle      (cycle),
        .sync       (sync),
        .addrOut    (addrOut),
        .opr        (opr),
        .opa        (opa),
        .secondWord (secondWord),
        .operand2   (operand2),
        .pc         (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // One instruction cycle: ROM nibbles at M1/M2, decoder jump at X3, optional stray jump at M2,
    // and the state expected once the X3 edge has passed.
    typedef struct {
        logic [3:0]  m1;
        logic [3:0]  m2;
        logic        jump;
        logic [11:0] jAddr;
        logic        stray;
        logic [3:0]  eOpr;
        logic [3:0]  eOpa;
        logic        eSw;
        logic [7:0]  eOp2;
        logic [11:0] ePc;
    } instrVec_t;

    instrVec_t tbl [14];

    int mPhase, mPc, mOpr, mOpa, mOp2, mSw, mPend;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic h, input logic [3:0] rd, input logic je,
                                 input logic [11:0] ja);
        hold     = h;
        romData  = rd;
        jumpEn   = je;
        jumpAddr = ja;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] dutVec();
        return 64'({cycle, sync, addrOut, opr, opa, secondWord, operand2, pc});
    endfunction

    task automatic modelReset();
        mPhase = 0; mPc = 0; mOpr = 0; mOpa = 0; mOp2 = 0; mSw = 0; mPend = 0;
    endtask

    // Instruction-level view: nibbles land in opcode/operand or in the second word,
    // and the PC moves once per eight-clock instruction.
    task automatic modelEdge(input bit h, input int rd, input bit je, input int ja);
        if (h) return;
        if (mPhase == 3) begin
            if (mSw != 0) mOp2 = rd * 16 + mOp2 % 16;
            else          mOpr = rd;
        end
        if (mPhase == 4) begin
            if (mSw != 0) begin
                mOp2 = (mOp2 / 16) * 16 + rd;
            end else begin
                mOpa = rd;
                if (mOpr == 1 || mOpr == 4 || mOpr == 5 || mOpr == 7 || (mOpr == 2 && rd % 2 == 0))
                    mPend = 1;
            end
        end
        if (mPhase == 7) begin
            if (je) begin
                mPc = ja;
                mSw = 0;
            end else begin
                mPc = (mPc + 1) % 4096;
                mSw = mPend;
            end
            mPend = 0;
        end
        mPhase = (mPhase + 1) % 8;
    endtask

    function automatic logic [63:0] modelVec();
        int addr;
        addr = (mPhase < 3) ? (mPc >> (4 * mPhase)) % 16 : 0;
        return 64'({3'(mPhase), mPhase == 7, 4'(addr), 4'(mOpr), 4'(mOpa), 1'(mSw),
                    8'(mOp2), 12'(mPc)});
    endfunction

    logic [3:0]  rd;
    logic        je;
    logic [11:0] ja;
    logic        h;
    logic [3:0]  expAddr;
    logic [11:0] prevPc;
    logic        prevSw;
    int          nxt;

    initial begin
        //                m1    m2    jump  jAddr    stray opr   opa   sw    op2    pc
        tbl[0]  = '{4'h0, 4'h0, 1'b0, 12'h000, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 12'h001};
        tbl[1]  = '{4'h0, 4'h0, 1'b0, 12'h000, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 12'h002};
        tbl[2]  = '{4'h0, 4'h0, 1'b1, 12'h123, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 12'h123};
        tbl[3]  = '{4'h8, 4'h5, 1'b0, 12'h000, 1'b1, 4'h8, 4'h5, 1'b0, 8'h00, 12'h124};
        tbl[4]  = '{4'h4, 4'hA, 1'b0, 12'h000, 1'b0, 4'h4, 4'hA, 1'b1, 8'h00, 12'h125};
        tbl[5]  = '{4'hB, 4'hC, 1'b1, 12'hABC, 1'b0, 4'h4, 4'hA, 1'b0, 8'hBC, 12'hABC};
        tbl[6]  = '{4'h2, 4'h4, 1'b0, 12'h000, 1'b0, 4'h2, 4'h4, 1'b1, 8'hBC, 12'hABD};
        tbl[7]  = '{4'h7, 4'h7, 1'b0, 12'h000, 1'b0, 4'h2, 4'h4, 1'b0, 8'h77, 12'hABE};
        tbl[8]  = '{4'h2, 4'h5, 1'b0, 12'h000, 1'b0, 4'h2, 4'h5, 1'b0, 8'h77, 12'hABF};
        tbl[9]  = '{4'h1, 4'h2, 1'b1, 12'hFFF, 1'b0, 4'h1, 4'h2, 1'b0, 8'h77, 12'hFFF};
        tbl[10] = '{4'h0, 4'h0, 1'b0, 12'h000, 1'b1, 4'h0, 4'h0, 1'b0, 8'h77, 12'h000};
        tbl[11] = '{4'h5, 4'h3, 1'b0, 12'h000, 1'b0, 4'h5, 4'h3, 1'b1, 8'h77, 12'h001};
        tbl[12] = '{4'h7, 4'h1, 1'b0, 12'h000, 1'b0, 4'h5, 4'h3, 1'b0, 8'h71, 12'h002};
        tbl[13] = '{4'h7, 4'h1, 1'b0, 12'h000, 1'b0, 4'h7, 4'h1, 1'b1, 8'h71, 12'h003};

        rstN = 1'b0; hold = 1'b0; romData = 4'h0; jumpEn = 1'b0; jumpAddr = 12'h000;
        #2;
        checkOutput("resetState", dutVec(), 64'h0);
        @(posedge clk);
        #1;
        rstN = 1'b1;

        prevPc = 12'h000;
        prevSw = 1'b0;
        for (int r = 0; r < 14; r++) begin
            for (int k = 0; k < 8; k++) begin
                rd = (k == 3) ? tbl[r].m1 : (k == 4) ? tbl[r].m2 : 4'h0;
                je = (k == 7) ? tbl[r].jump : (k == 4) ? tbl[r].stray : 1'b0;
                ja = (k == 7) ? tbl[r].jAddr : 12'h777;
                applyStimulus(1'b0, rd, je, ja);
                nxt = (k + 1) % 8;
                case (nxt)
                    0:       expAddr = tbl[r].ePc[3:0];
                    1:       expAddr = prevPc[7:4];
                    2:       expAddr = prevPc[11:8];
                    default: expAddr = 4'h0;
                endcase
                checkOutput("phase", 64'({cycle, sync, addrOut}),
                            64'({3'(nxt), nxt == 7, expAddr}));
                if (k == 4)
                    checkOutput("captureAtX1", 64'({opr, opa, operand2, secondWord}),
                                64'({tbl[r].eOpr, tbl[r].eOpa, tbl[r].eOp2, prevSw}));
                if (k == 7) begin
                    checkOutput("pcUpdate", 64'({pc, secondWord}), 64'({tbl[r].ePc, tbl[r].eSw}));
                    prevPc = tbl[r].ePc;
                    prevSw = tbl[r].eSw;
                end
            end
        end

        // Second-word cycle for the ISZ above: freeze at M2, then reset during X1.
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 4'h0, 1'b0, 12'h000);
        applyStimulus(1'b0, 4'hE, 1'b0, 12'h000);
        checkOutput("secondHigh", 64'({cycle, operand2}), 64'({3'd4, 8'hE1}));
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 4'h6, 1'b1, 12'h555);
            checkOutput("holdFrozen", 64'({cycle, pc, opr, opa, operand2, secondWord}),
                        64'({3'd4, 12'h003, 4'h7, 4'h1, 8'hE1, 1'b1}));
        end
        applyStimulus(1'b0, 4'hD, 1'b0, 12'h000);
        checkOutput("holdResume", 64'({cycle, operand2, opr, opa}),
                    64'({3'd5, 8'hED, 4'h7, 4'h1}));
        rstN = 1'b0;
        #1;
        checkOutput("midReset", dutVec(), 64'h0);
        @(posedge clk);
        #1;
        checkOutput("resetHeld", dutVec(), 64'h0);
        rstN = 1'b1;
        for (int k = 0; k < 8; k++) applyStimulus(1'b0, 4'h0, 1'b0, 12'h000);
        checkOutput("afterReset", 64'({cycle, pc, secondWord}), 64'({3'd0, 12'h001, 1'b0}));

        rstN = 1'b0;
        #1;
        modelReset();
        checkOutput("randomStartReset", dutVec(), modelVec());
        rstN = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            h  = ($urandom_range(0, 9) == 0);
            rd = 4'($urandom_range(0, 15));
            je = ($urandom_range(0, 4) == 0);
            ja = 12'($urandom_range(0, 4095));
            modelEdge(h, int'(rd), je, int'(ja));
            applyStimulus(h, rd, je, ja);
            checkOutput("random", dutVec(), modelVec());
            if ($urandom_range(0, 199) == 0) begin
                rstN = 1'b0;
                #1;
                modelReset();
                checkOutput("randomReset", dutVec(), modelVec());
                rstN = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
